// File: rtl/pxs_sprite_anim_ctrl.sv
// Vertical-blanking sprite controller: after each end of frame it updates position, bounce
// direction and animation frame. RGBStr_i layout is {XC[9:0], YC[9:0], colour/sync[5:0]}.
module pxs_sprite_anim_ctrl #(
  parameter int VISIBLECOLS   = 640,
  parameter int VISIBLEROWS   = 480,
  parameter int WIDTH_SPRITE  = 32,
  parameter int HEIGHT_SPRITE = 40,
  parameter int BORDER        = 0,
  parameter int N_SPRITE      = 11,
  parameter int LOOP_IDX      = 5,
  parameter int FRAME_DIV     = 8,
  parameter int X_INIT        = 500,
  parameter int Y_INIT        = 220,
  parameter int SPEED_INIT    = 1,
  parameter int VMOVE         = 0
) (
  input  logic        px_clk,
  input  logic        rst_n,
  input  logic [25:0] RGBStr_i,
  input  logic        run,
  input  logic        speed_we,
  input  logic [4:0]  speed_i,
  output logic [9:0]  x_sprite,
  output logic [9:0]  y_sprite,
  output logic        dx,
  output logic        dy,
  output logic [3:0]  index_img,
  output logic        upd_done,
  output logic        busy
);

  localparam logic [10:0] XMIN = 11'(BORDER);
  localparam logic [10:0] YMIN = 11'(BORDER);
  localparam logic [10:0] XMAX = 11'(VISIBLECOLS - WIDTH_SPRITE - BORDER);
  localparam logic [10:0] YMAX = 11'(VISIBLEROWS - HEIGHT_SPRITE - BORDER);
  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic [1:0] {IDLE, MOVE, ANIM, DONE} state_t;
  state_t state, state_nxt;

  logic [9:0]    xc, yc;
  logic          endframe, go;
  logic [4:0]    speed_q, speed_sh;
  logic [CW-1:0] frame_cnt;
  logic          bounce_q;
  logic [11:0]   x_mv, y_mv;
  logic          unused_ok;

  assign xc        = RGBStr_i[25:16];
  assign yc        = RGBStr_i[15:6];
  assign unused_ok = ^RGBStr_i[5:0];
  assign endframe  = (xc == 10'(VISIBLECOLS - 1)) && (yc == 10'(VISIBLEROWS - 1));
  assign go        = endframe && run;

  // Returns {bounce, dir, pos}; clamps to the limit and flips direction instead of wrapping.
  function automatic logic [11:0] move_axis(input logic [9:0] pos, input logic dir,
                                            input logic [4:0] spd,
                                            input logic [10:0] lo, input logic [10:0] hi);
    logic [10:0] p, s;
    p = {1'b0, pos};
    s = {6'b0, spd};
    move_axis = {1'b0, dir, pos};
    if (spd != 5'd0) begin
      if (!dir) begin
        if (p + s >= hi) move_axis = {1'b1, 1'b1, hi[9:0]};
        else             move_axis = {1'b0, 1'b0, 10'(p + s)};
      end else begin
        if (p <= lo + s) move_axis = {1'b1, 1'b0, lo[9:0]};
        else             move_axis = {1'b0, 1'b1, 10'(p - s)};
      end
    end
  endfunction

  assign x_mv = move_axis(x_sprite, dx, speed_q, XMIN, XMAX);
  assign y_mv = move_axis(y_sprite, dy, speed_q, YMIN, YMAX);

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = MOVE;
      MOVE:    state_nxt = ANIM;
      ANIM:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    upd_done = (state == DONE);
    busy     = (state != IDLE);
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sprite  <= 10'(X_INIT);
      y_sprite  <= 10'(Y_INIT);
      dx        <= 1'b1;
      dy        <= 1'b0;
      index_img <= 4'd0;
      frame_cnt <= '0;
      speed_q   <= 5'(SPEED_INIT);
      speed_sh  <= 5'(SPEED_INIT);
      bounce_q  <= 1'b0;
    end else begin
      if (speed_we) speed_sh <= speed_i;
      case (state)
        // speed_sh is sampled before this edge's write, so a same-cycle write waits a frame
        IDLE: if (go) speed_q <= speed_sh;
        MOVE: begin
          x_sprite <= x_mv[9:0];
          dx       <= x_mv[10];
          bounce_q <= x_mv[11];
          if (VMOVE != 0) begin
            y_sprite <= y_mv[9:0];
            dy       <= y_mv[10];
          end
        end
        ANIM: begin
          if (bounce_q) begin
            index_img <= 4'd0;
            frame_cnt <= '0;
          end else if (frame_cnt == CW'(FRAME_DIV - 1)) begin
            frame_cnt <= '0;
            index_img <= (index_img == 4'(N_SPRITE - 1)) ? 4'(LOOP_IDX) : index_img + 4'd1;
          end else begin
            frame_cnt <= frame_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pxs_sprite_anim_ctrl.sv
// Bench for pxs_sprite_anim_ctrl: a table of frame updates checked cycle by cycle against a
// behavioural model via a scoreboard, plus reset-abort and vertical-bounce sequences.
module tb_pxs_sprite_anim_ctrl;

  logic        px_clk = 1'b0;
  logic        rst_n, run, speed_we;
  logic [25:0] rgb;
  logic [4:0]  speed_i;
  logic [9:0]  x0, y0, x1, y1;
  logic        dx0, dy0, dx1, dy1, done0, done1, busy0, busy1;
  logic [3:0]  idx0, idx1;

  always #5 px_clk = ~px_clk;

  pxs_sprite_anim_ctrl #(.VMOVE(0)) u_h (
    .px_clk(px_clk), .rst_n(rst_n), .RGBStr_i(rgb), .run(run), .speed_we(speed_we),
    .speed_i(speed_i), .x_sprite(x0), .y_sprite(y0), .dx(dx0), .dy(dy0), .index_img(idx0),
    .upd_done(done0), .busy(busy0));

  pxs_sprite_anim_ctrl #(.VMOVE(1)) u_v (
    .px_clk(px_clk), .rst_n(rst_n), .RGBStr_i(rgb), .run(run), .speed_we(speed_we),
    .speed_i(speed_i), .x_sprite(x1), .y_sprite(y1), .dx(dx1), .dy(dy1), .index_img(idx1),
    .upd_done(done1), .busy(busy1));

  localparam logic [25:0] EF   = {10'd639, 10'd479, 6'd0};
  localparam logic [25:0] NOEF = {10'd100, 10'd479, 6'd0};

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model; y tracks the VMOVE=1 instance, the VMOVE=0 instance stays at 220/down.
  int mx, mdx, my, mdy, midx, mcnt, msh, mq;

  task automatic m_reset();
    mx = 500; mdx = 1; my = 220; mdy = 0; midx = 0; mcnt = 0; msh = 1; mq = 1;
  endtask

  task automatic m_axis(inout int p, inout int d, input int s, input int lo, input int hi,
                        output bit b);
    b = 0;
    if (s != 0) begin
      if (d == 0) begin
        if (p + s >= hi) begin p = hi; d = 1; b = 1; end
        else p = p + s;
      end else begin
        if (p <= lo + s) begin p = lo; d = 0; b = 1; end
        else p = p - s;
      end
    end
  endtask

  typedef struct { int x; int dx; int y; int dy; int idx; } exp_t;
  exp_t sbq[$];

  task automatic m_update();
    bit bx, by;
    exp_t e;
    mq = msh;
    m_axis(mx, mdx, mq, 0, 608, bx);
    m_axis(my, mdy, mq, 0, 440, by);
    if (bx) begin midx = 0; mcnt = 0; end
    else if (mcnt == 7) begin mcnt = 0; midx = (midx == 10) ? 5 : midx + 1; end
    else mcnt++;
    e.x = mx; e.dx = mdx; e.y = my; e.dy = mdy; e.idx = midx;
    sbq.push_back(e);
  endtask

  typedef struct {
    bit run; bit wr; bit wr_at_ef; int spd; bit drop;
    int ex_x; int ex_dx; int ex_idx;   // -1 = not pinned
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit r, bit w, bit wae, int s, bit d, int ex, int edx, int ei);
    vec_t v;
    v.run = r; v.wr = w; v.wr_at_ef = wae; v.spd = s; v.drop = d;
    v.ex_x = ex; v.ex_dx = edx; v.ex_idx = ei;
    tbl.push_back(v);
  endfunction

  bit saw_y0, saw_y440;

  task automatic apply(input vec_t v);
    int ox, oidx;
    exp_t e;
    if (v.wr) begin
      @(negedge px_clk); speed_we = 1; speed_i = 5'(v.spd);
      @(negedge px_clk); speed_we = 0;
      msh = v.spd;
    end
    ox = mx; oidx = midx;
    @(negedge px_clk);
    run = v.run; rgb = EF;
    speed_we = v.wr_at_ef; speed_i = 5'(v.spd);
    if (v.run) m_update();
    if (v.wr_at_ef) msh = v.spd;
    @(negedge px_clk);                         // T+1
    rgb = NOEF; speed_we = 0;
    if (v.drop) run = 0;
    if (!v.run) begin
      for (int c = 0; c < 3; c++) begin
        chk("idle_busy", busy0, 0);
        @(negedge px_clk);
      end
      chk("idle_x", x0, ox); chk("idle_idx", idx0, oidx);
    end else begin
      chk("t1_busy", busy0, 1); chk("t1_x_old", x0, ox); chk("t1_done", done0, 0);
      @(negedge px_clk);                       // T+2
      e = sbq[0];
      chk("t2_x", x0, e.x); chk("t2_dx", dx0, e.dx);
      chk("t2_y_frozen", y0, 220); chk("t2_dy_frozen", dy0, 0);
      chk("t2_vx", x1, e.x); chk("t2_vy", y1, e.y); chk("t2_vdy", dy1, e.dy);
      chk("t2_idx_old", idx0, oidx); chk("t2_done", done0, 0); chk("t2_busy", busy0, 1);
      if (y1 == 10'd0) saw_y0 = 1;
      if (y1 == 10'd440) saw_y440 = 1;
      @(negedge px_clk);                       // T+3
      e = sbq.pop_front();
      chk("t3_idx", idx0, e.idx); chk("t3_vidx", idx1, e.idx);
      chk("t3_done", done0, 1); chk("t3_vdone", done1, 1); chk("t3_busy", busy0, 1);
      @(negedge px_clk);                       // T+4
      chk("t4_done", done0, 0); chk("t4_busy", busy0, 0);
    end
    if (v.ex_x   >= 0) chk("pin_x", x0, v.ex_x);
    if (v.ex_dx  >= 0) chk("pin_dx", dx0, v.ex_dx);
    if (v.ex_idx >= 0) chk("pin_idx", idx0, v.ex_idx);
  endtask

  initial begin
    vec_t v;
    rst_n = 0; run = 0; speed_we = 0; speed_i = 0; rgb = NOEF;
    saw_y0 = 0; saw_y440 = 0;
    m_reset();

    add(1, 0, 0, 0, 0, 499, 1, 0);
    add(0, 0, 0, 0, 0, 499, 1, 0);
    for (int i = 2; i <= 88; i++)
      add(1, 0, 0, 0, i == 50,
          (i == 8) ? 492 : (i == 80) ? 420 : (i == 88) ? 412 : -1, -1,
          (i == 8) ? 1 : (i == 80) ? 10 : (i == 88) ? 5 : -1);
    add(1, 0, 1, 7, 0, 411, 1, -1);
    add(1, 0, 0, 0, 0, 404, 1, -1);
    for (int i = 91; i <= 102; i++) add(1, i == 91, 0, 31, 0, (i == 102) ? 32 : -1, -1, -1);
    add(1, 1, 0, 30, 0, 2, 1, -1);
    add(1, 1, 0, 3, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 3, 0, -1);
    for (int i = 106; i <= 124; i++) add(1, i == 106, 0, 31, 0, (i == 124) ? 592 : -1, -1, -1);
    add(1, 1, 0, 14, 0, 606, 0, -1);
    add(1, 1, 0, 2, 0, 608, 1, 0);
    add(1, 1, 0, 0, 0, 608, 1, 0);

    repeat (3) @(negedge px_clk);
    chk("rst_x", x0, 500); chk("rst_y", y0, 220); chk("rst_dx", dx0, 1); chk("rst_dy", dy0, 0);
    chk("rst_idx", idx0, 0); chk("rst_done", done0, 0); chk("rst_busy", busy0, 0);
    rst_n = 1;

    foreach (tbl[i]) apply(tbl[i]);

    // Long vertical sweep on the VMOVE instance to reach both y limits.
    for (int i = 0; i < 40; i++) begin
      v.run = 1; v.wr = (i == 0); v.wr_at_ef = 0; v.spd = 31; v.drop = 0;
      v.ex_x = -1; v.ex_dx = -1; v.ex_idx = -1;
      apply(v);
    end
    chk("y_hit_0", saw_y0, 1); chk("y_hit_440", saw_y440, 1);

    // Reset while in ANIM: everything snaps back and the done pulse never appears.
    @(negedge px_clk); run = 1; rgb = EF;
    @(negedge px_clk); rgb = NOEF;
    @(negedge px_clk);
    rst_n = 0;
    #1;
    chk("arst_x", x0, 500); chk("arst_vy", y1, 220); chk("arst_dx", dx0, 1);
    chk("arst_idx", idx0, 0); chk("arst_busy", busy0, 0); chk("arst_done", done0, 0);
    @(negedge px_clk); chk("arst_done2", done0, 0);
    rst_n = 1;
    m_reset();
    v.run = 1; v.wr = 0; v.wr_at_ef = 0; v.spd = 0; v.drop = 0;
    v.ex_x = 499; v.ex_dx = 1; v.ex_idx = 0;
    apply(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
